// File: rtl/mysystem_sysid_checker_if.sv
// Avalon-MM read-only master/slave bundle between the sysid checker and the
// interconnect.
interface mysystem_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/mysystem_sysid_checker.sv
// Boot-time sysid checker: reads ID and timestamp words over Avalon-MM,
// compares them with build-time values and holds a pass/fail verdict.
module mysystem_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h8765_4321,
    parameter logic [31:0] EXPECTED_TS    = 32'h694E_0D2C,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    mysystem_sysid_checker_if.master         avm,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             id_ok,
    output logic                             ts_ok,
    output logic                             timeout_err,
    output logic [31:0]                      id_word,
    output logic [31:0]                      ts_word,
    output logic [1:0]                       retry_count
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, RETRY, CHECK, DONE} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d, tmo_sat;
    logic [1:0]  retry_q, retry_d;
    logic [31:0] id_word_q, id_word_d, ts_word_q, ts_word_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, terr_q, terr_d;
    logic        rd_q, rd_d, addr_q, addr_d;
    logic        timeout_hit;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        id_word_d = id_word_q;
        ts_word_d = ts_word_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        terr_d    = terr_q;

        // Saturating stall counter; the read is abandoned when it reaches the limit.
        tmo_sat     = (tmo_q == CW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + CW'(1);
        timeout_hit = (tmo_sat == CW'(TIMEOUT_CYCLES));

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RD_ID;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    terr_d  = 1'b0;
                    retry_d = '0;
                    tmo_d   = '0;
                end
            end
            RD_ID, RD_TS: begin
                if (!avm.avm_waitrequest) begin
                    tmo_d = '0;
                    if (state_q == RD_ID) begin
                        id_word_d = avm.avm_readdata;
                        state_d   = RD_TS;
                    end else begin
                        ts_word_d = avm.avm_readdata;
                        state_d   = CHECK;
                    end
                end else if (timeout_hit) begin
                    tmo_d = '0;
                    if (retry_q < 2'(MAX_RETRIES)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = RETRY;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        terr_d  = 1'b1;
                        pass_d  = 1'b0;
                    end
                end else begin
                    tmo_d = tmo_sat;
                end
            end
            RETRY: state_d = RD_ID;
            CHECK: begin
                id_ok_d = (id_word_q == EXPECTED_ID);
                ts_ok_d = (ts_word_q == EXPECTED_TS);
                pass_d  = (id_word_q == EXPECTED_ID) && (ts_word_q == EXPECTED_TS) && !terr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are registered from the next state so they rise with RD_* entry.
        rd_d   = (state_d == RD_ID) || (state_d == RD_TS);
        addr_d = (state_d == RD_TS);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            retry_q   <= '0;
            id_word_q <= '0;
            ts_word_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            terr_q    <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            id_word_q <= id_word_d;
            ts_word_q <= ts_word_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            terr_q    <= terr_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
        end
    end

    assign avm.avm_read    = rd_q;
    assign avm.avm_address = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout_err     = terr_q;
    assign id_word         = id_word_q;
    assign ts_word         = ts_word_q;
    assign retry_count     = retry_q;

endmodule
